// File: rtl/refclk_out_pkg.sv
// Shared types and defaults for the GT reference-clock output controller.
package refclk_out_pkg;

    // Controller states; 2-bit encoding.
    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    localparam int SETTLE_CYCLES_DEF = 16;
    localparam int DIV_W_DEF         = 4;

    // The shared counter must hold both the settle count (up to 255) and div_q.
    function automatic int cnt_width(input int div_w);
        return (div_w > 8) ? div_w : 8;
    endfunction

endpackage

// File: rtl/refclk_half_cnt.sv
// Load/terminal-count counter shared by the settle interval and the
// half-period timer. Counts 0..lim_i, flags tc_o on the last count and
// wraps to 0 on the following enabled edge.
module refclk_half_cnt
    import refclk_out_pkg::*;
#(
    parameter int CW = cnt_width(DIV_W_DEF)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [CW-1:0] lim_i,
    output logic          tc_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == lim_i);

    // Next count: clear has priority, otherwise count up and wrap at terminal.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/refclk_out_ctrl.sv
// Drives a GT refclk output buffer: enables the buffer with the clock held
// low for a settle interval, then toggles at a programmable half-period.
// Shutdown always finishes the current high phase and keeps the clock low
// for a cycle before the buffer is disabled, so no runt pulse escapes.
module refclk_out_ctrl
    import refclk_out_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int DIV_W         = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_req,
    input  logic [DIV_W-1:0] div_sel,
    output logic             refclk_o,
    output logic             ceb_o,
    output logic             active,
    output logic             busy
);

    localparam int CW = cnt_width(DIV_W);

    logic [1:0]       rsync_q;
    logic             rdy;
    logic             en_q;
    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             refclk_q, refclk_d;
    logic             ceb_q, ceb_d;
    logic             active_q, active_d;
    logic             busy_q, busy_d;
    logic             cnt_clr, cnt_en, tc;
    logic [CW-1:0]    lim;

    // Reset assertion is immediate; release is held off by two flops so the
    // FSM never moves on a partially-released reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsync_q <= 2'b00;
        end else begin
            rsync_q <= {rsync_q[0], 1'b1};
        end
    end

    assign rdy = rsync_q[1];

    // Request is sampled once; the FSM acts on the sampled value, which also
    // keeps every output free of any combinational path from the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en_req;
        end
    end

    // Counter is held clear in OFF so each SETTLE and RUN starts from zero.
    assign cnt_clr = !rdy || (state_q == OFF);
    assign cnt_en  = rdy && (state_q != OFF);
    assign lim     = (state_q == SETTLE) ? CW'(SETTLE_CYCLES - 1) : CW'(div_q);

    refclk_half_cnt #(
        .CW (CW)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .lim_i (lim),
        .tc_o  (tc)
    );

    // Next state, latched divider and next clock level.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        refclk_d = refclk_q;
        case (state_q)
            OFF: begin
                refclk_d = 1'b0;
                if (en_q) begin
                    state_d = SETTLE;
                    div_d   = div_sel;
                end
            end
            SETTLE: begin
                refclk_d = 1'b0;
                if (!en_q) begin
                    state_d = OFF;
                end else if (tc) begin
                    state_d  = RUN;
                    refclk_d = 1'b1;
                end
            end
            RUN: begin
                if (!en_q) begin
                    // Low phase can be cut immediately; a high phase must finish.
                    if (!refclk_q) begin
                        state_d = OFF;
                    end else begin
                        state_d = DRAIN;
                        if (tc) begin
                            refclk_d = 1'b0;
                        end
                    end
                end else if (tc) begin
                    refclk_d = ~refclk_q;
                end
            end
            DRAIN: begin
                // Requests are ignored here; leave only after one low cycle.
                if (!refclk_q) begin
                    state_d = OFF;
                end else if (tc) begin
                    refclk_d = 1'b0;
                end
            end
            default: begin
                state_d  = OFF;
                refclk_d = 1'b0;
            end
        endcase
    end

    // Registered status outputs decoded from the next state.
    always_comb begin
        ceb_d    = (state_d == OFF);
        active_d = (state_d == RUN);
        busy_d   = (state_d == SETTLE) || (state_d == DRAIN);
    end

    // State and output registers; frozen until the reset release is synchronised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= OFF;
            div_q    <= '0;
            refclk_q <= 1'b0;
            ceb_q    <= 1'b1;
            active_q <= 1'b0;
            busy_q   <= 1'b0;
        end else if (rdy) begin
            state_q  <= state_d;
            div_q    <= div_d;
            refclk_q <= refclk_d;
            ceb_q    <= ceb_d;
            active_q <= active_d;
            busy_q   <= busy_d;
        end
    end

    assign refclk_o = refclk_q;
    assign ceb_o    = ceb_q;
    assign active   = active_q;
    assign busy     = busy_q;

endmodule

// File: doc/refclk_out_ctrl.md
REFCLK_OUT_CTRL -- requirements
Module: refclk_out_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16, sets the number of cycles the driver is enabled with the output held low before toggling; legal range 1..255.
REQ-002 Parameter DIV_W, default 4, sets the width of div_sel.
REQ-003 Port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port en_req, input, 1 bit: level request to drive the reference clock out; synchronous to clk.
REQ-006 Port div_sel, input, DIV_W bits: half-period in clk cycles minus 1.
REQ-007 Port refclk_o, output, 1 bit: registered clock feeding the GT refclk output buffer I pin.
REQ-008 Port ceb_o, output, 1 bit: registered active-low buffer enable feeding the buffer CEB pin.
REQ-009 Port active, output, 1 bit: high while in RUN.
REQ-010 Port busy, output, 1 bit: high in SETTLE and DRAIN.

Function
REQ-011 The block SHALL implement the states OFF, SETTLE, RUN and DRAIN.
REQ-012 In OFF: ceb_o=1 and refclk_o=0; en_req=1 moves to SETTLE on the next edge, latching div_sel into div_q and clearing the counter.
REQ-013 In SETTLE: ceb_o=0 and refclk_o=0; the count runs to SETTLE_CYCLES-1, then moves to RUN with refclk_o=1 on that same edge.
REQ-014 Latency: en_req first sampled high at edge t0 gives ceb_o=0 from t0+1 and the first refclk_o rise at edge t0+SETTLE_CYCLES+1.
REQ-015 In RUN: refclk_o SHALL toggle every div_q+1 cycles, giving a period of 2*(div_q+1) cycles at 50% duty; div_sel changes in RUN are ignored.
REQ-016 div_q=0 SHALL give refclk_o = clk/2; div_q=all-ones SHALL give a half-period of 2^DIV_W cycles; the counter wraps to 0 at each toggle.
REQ-017 en_req=0 in RUN: if refclk_o=0, go to OFF next edge; else go to DRAIN.
REQ-018 In DRAIN: the current high phase completes unshortened; at its end refclk_o falls, and one edge later the state is OFF with ceb_o=1. refclk_o SHALL be low for at least one cycle before ceb_o rises; no runt pulse is permitted.
REQ-019 en_req=0 in SETTLE SHALL return to OFF on the next edge; refclk_o never rises.
REQ-020 en_req=1 during DRAIN SHALL be ignored until OFF is reached; OFF with en_req=1 re-enters SETTLE on the next edge, with a full settle.
REQ-021 active=1 exactly in RUN and DRAIN excluded; busy=1 exactly in SETTLE or DRAIN; all outputs are registered, with no combinational path from inputs.

Reset
REQ-022 rst_n=0 SHALL immediately force state=OFF, refclk_o=0, ceb_o=1, active=0, busy=0 and clear the counter and div_q, regardless of the current state.
REQ-023 Reset deassertion is synchronised internally with a 2-flop stage; the first state change may occur no earlier than the 2nd rising clk edge after rst_n rises.

Structure
REQ-024 Package refclk_out_pkg SHALL hold the state enum (OFF, SETTLE, RUN, DRAIN; 2 bits) and the default constants SETTLE_CYCLES_DEF=16 and DIV_W_DEF=4.
REQ-025 The counter is shared by SETTLE and RUN and is sized max(8, DIV_W) bits.
REQ-026 One sub-module is natural: refclk_half_cnt (load/terminal-count half-period counter); everything else is flat in one FSM.

Verification
REQ-027 Reset, en_req=1 at t0, div_sel=3, SETTLE_CYCLES=16 -> ceb_o=0 at t0+1, first refclk_o rise at t0+17, period 8 with 4 high.
REQ-028 div_sel=0 -> refclk_o toggles every cycle; div_sel changed to 7 mid-RUN -> period stays 2.
REQ-029 en_req dropped 1 cycle into a 4-cycle high phase -> 3 more high cycles, then low, then ceb_o=1 one edge later; busy=1 throughout DRAIN.
REQ-030 en_req pulsed 5 cycles during SETTLE -> refclk_o stays 0 and ceb_o returns to 1 after the drop.
REQ-031 en_req re-raised during DRAIN -> OFF for one cycle, then a full 16-cycle SETTLE before the next rise.
REQ-032 rst_n asserted mid-RUN while refclk_o=1 -> refclk_o=0 and ceb_o=1 with no clock edge required; restart after release matches REQ-027.
